// File: rtl/blake512_block_sched.sv
// ---------------------------------------------------------------------------
// blake512_block_sched
//
// Block scheduler for a BLAKE-512 compression core. It accepts message blocks
// one at a time and keeps the running bit counter t. For each accepted block
// it starts the round controller with a one-cycle pulse and waits for that
// block to finish. After the last block of a message it presents the digest
// until the consumer takes it. A watchdog guards the wait for the round
// controller. A timeout raises a sticky error and abandons the message.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   blk_valid    message block offered
//   blk_ready    scheduler can accept a block (IDLE only)
//   blk_last     offered block is the final block of the message
//   blk_bits     message bits in the offered block (saturated to 1024)
//   core_ena     one-cycle start pulse to the round controller
//   core_first   chain value comes from IV (first block of a message)
//   core_t       counter t for the compression core
//   core_done    one-cycle completion pulse from the round controller
//   hash_valid   digest in the chain register is final
//   hash_ready   consumer takes the digest
//   err_timeout  sticky watchdog error, cleared only by rst
// ---------------------------------------------------------------------------
module blake512_block_sched #(
  parameter int MAX_WAIT = 200,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_last,
  input  logic [10:0]  blk_bits,
  output logic         core_ena,
  output logic         core_first,
  output logic [127:0] core_t,
  input  logic         core_done,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic         err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WD_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // A block never carries more than 1024 message bits; larger requests clamp.
  function automatic logic [10:0] sat_bits(input logic [10:0] bits);
    if (bits > 11'd1024) begin
      return 11'd1024;
    end else begin
      return bits;
    end
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;

  logic           blk_ready_r;
  logic           core_ena_r;
  logic           hash_valid_r;
  logic           blk_ready_nxt_s;
  logic           core_ena_nxt_s;
  logic           hash_valid_nxt_s;

  logic [127:0]   t_acc_r;
  logic [127:0]   core_t_r;
  logic           last_r;
  logic           first_r;
  logic [CNT_W-1:0] wd_r;
  logic           err_r;

  logic           hs_s;
  logic [10:0]    bits_s;
  logic [127:0]   t_sum_s;
  logic           done_s;
  logic           wd_hit_s;
  logic           timeout_s;
  logic           handoff_s;

  // The handshake is qualified by the registered ready. That register stays
  // low for the first cycle after rst releases, even though state is IDLE.
  assign hs_s      = blk_valid & blk_ready_r & (state_r == IDLE);
  assign bits_s    = sat_bits(blk_bits);
  assign t_sum_s   = t_acc_r + {117'd0, bits_s};
  assign done_s    = core_done & (state_r == WAIT);
  assign wd_hit_s  = (state_r == WAIT) & (wd_r == WAIT_LIM);
  // core_done in the same cycle as the limit wins, so no error is raised.
  assign timeout_s = wd_hit_s & ~core_done;
  assign handoff_s = hash_ready & (state_r == OUT);

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      blk_ready_r  <= 1'b0;
      core_ena_r   <= 1'b0;
      hash_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      blk_ready_r  <= blk_ready_nxt_s;
      core_ena_r   <= core_ena_nxt_s;
      hash_valid_r <= hash_valid_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          if (last_r) begin
            state_nxt_s = OUT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (wd_hit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      OUT: begin
        if (hash_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state. The outputs are registered, so each
  // one lines up with the state it belongs to.
  always_comb begin
    blk_ready_nxt_s  = 1'b0;
    core_ena_nxt_s   = 1'b0;
    hash_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    blk_ready_nxt_s  = 1'b1;
      ISSUE:   core_ena_nxt_s   = 1'b1;
      WAIT:    core_ena_nxt_s   = 1'b0;
      OUT:     hash_valid_nxt_s = 1'b1;
      default: blk_ready_nxt_s  = 1'b0;
    endcase
  end

  // Bit counter, per-block core_t, last flag and first-block flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_acc_r  <= 128'd0;
      core_t_r <= 128'd0;
      last_r   <= 1'b0;
      first_r  <= 1'b1;
    end else begin
      if (hs_s) begin
        t_acc_r <= t_sum_s;
      end else if (timeout_s || handoff_s) begin
        t_acc_r <= 128'd0;
      end else begin
        t_acc_r <= t_acc_r;
      end

      // A padding-only block is compressed with t = 0.
      if (hs_s) begin
        core_t_r <= (bits_s != 11'd0) ? t_sum_s : 128'd0;
        last_r   <= blk_last;
      end else begin
        core_t_r <= core_t_r;
        last_r   <= last_r;
      end

      if (done_s) begin
        first_r <= 1'b0;
      end else if (timeout_s || handoff_s) begin
        first_r <= 1'b1;
      end else begin
        first_r <= first_r;
      end
    end
  end

  // Watchdog. It counts WAIT cycles from 0, and the error flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r  <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      if ((state_r == WAIT) && (state_nxt_s == WAIT)) begin
        wd_r <= wd_r + WD_ONE;
      end else begin
        wd_r <= {CNT_W{1'b0}};
      end

      if (timeout_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign blk_ready   = blk_ready_r;
  assign core_ena    = core_ena_r;
  assign hash_valid  = hash_valid_r;
  assign core_first  = first_r;
  assign core_t      = core_t_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_blake512_block_sched.sv
module tb_blake512_block_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;
  logic [10:0]  blk_bits;
  logic         core_ena;
  logic         core_first;
  logic [127:0] core_t;
  logic         core_done;
  logic         hash_valid;
  logic         hash_ready;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           kind;   // 0: core issue, 1: digest presented
    logic [127:0] t;
    bit           first;
  } exp_t;

  exp_t exp_q[$];
  logic hv_prev;

  blake512_block_sched #(.MAX_WAIT(200), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
    .blk_bits(blk_bits),
    .core_ena(core_ena), .core_first(core_first), .core_t(core_t),
    .core_done(core_done),
    .hash_valid(hash_valid), .hash_ready(hash_ready),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT starts the core or shows a digest.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (core_ena) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_core_ena actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("event_is_issue", {127'd0, e.kind}, 128'd0);
          check("core_t", core_t, e.t);
          check("core_first", {127'd0, core_first}, {127'd0, e.first});
        end
      end
      if (hash_valid && !hv_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hash_valid actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("event_is_hash", {127'd0, e.kind}, 128'd1);
        end
      end
    end
    hv_prev <= hash_valid;
  end

  task automatic send(input logic [10:0] bits, input bit last, input logic [127:0] et, input bit ef);
    int n = 0;
    @(negedge clk);
    while (!blk_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) check("ready_wait_bound", {127'd0, blk_ready}, 128'd1);
    exp_q.push_back(exp_t'{1'b0, et, ef});
    blk_valid = 1'b1;
    blk_bits  = bits;
    blk_last  = last;
    @(negedge clk);
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    check("ena_latency", {127'd0, core_ena}, 128'd1);
  endtask

  // Called at the ISSUE-cycle negedge: pulse core_done during WAIT cycle n.
  task automatic done(input int n, input bit last);
    if (last) exp_q.push_back(exp_t'{1'b1, 128'd0, 1'b0});
    repeat (n + 1) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    if (last) check("hash_valid_after_done", {127'd0, hash_valid}, 128'd1);
    else      check("ready_after_done", {127'd0, blk_ready}, 128'd1);
  endtask

  task automatic handoff(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hash_valid_hold", {127'd0, hash_valid}, 128'd1);
    end
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    check("ready_after_handoff", {127'd0, blk_ready}, 128'd1);
    check("hash_valid_cleared", {127'd0, hash_valid}, 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; blk_valid = 1'b0; blk_last = 1'b0; blk_bits = 11'd0;
    core_done = 1'b0; hash_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_blk_ready", {127'd0, blk_ready}, 128'd0);
    check("rst_core_ena", {127'd0, core_ena}, 128'd0);
    check("rst_hash_valid", {127'd0, hash_valid}, 128'd0);
    check("rst_err", {127'd0, err_timeout}, 128'd0);
    check("rst_core_first", {127'd0, core_first}, 128'd1);
    check("rst_core_t", core_t, 128'd0);
    rst = 1'b0;
    #1;
    check("ready_before_first_edge", {127'd0, blk_ready}, 128'd0);
    @(negedge clk);
    check("ready_first_edge", {127'd0, blk_ready}, 128'd1);

    // Single full block, last.
    send(11'd1024, 1'b1, 128'd1024, 1'b1);
    done(3, 1'b1);
    handoff(2);

    // Three blocks 1024, 1024, 200.
    send(11'd1024, 1'b0, 128'd1024, 1'b1);
    done(0, 1'b0);
    send(11'd1024, 1'b0, 128'd2048, 1'b0);
    done(0, 1'b0);
    check("no_hash_mid_message", {127'd0, hash_valid}, 128'd0);
    send(11'd200, 1'b1, 128'd2248, 1'b0);
    done(1, 1'b1);
    handoff(0);

    // Padding-only final block.
    send(11'd1024, 1'b0, 128'd1024, 1'b1);
    done(0, 1'b0);
    send(11'd0, 1'b1, 128'd0, 1'b0);
    done(0, 1'b1);
    check("t_acc_in_out", dut.t_acc_r, 128'd1024);
    handoff(1);
    check("t_acc_after_handoff", dut.t_acc_r, 128'd0);

    // Oversized block saturates.
    send(11'd2047, 1'b1, 128'd1024, 1'b1);
    done(0, 1'b1);
    handoff(0);

    // Counter wrap.
    force dut.t_acc_r = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FE00;
    send(11'd1024, 1'b1, 128'd512, 1'b1);
    release dut.t_acc_r;
    done(2, 1'b1);
    check("wrap_no_err", {127'd0, err_timeout}, 128'd0);
    handoff(0);

    // core_done exactly at the watchdog limit wins.
    send(11'd64, 1'b0, 128'd64, 1'b1);
    done(200, 1'b0);
    check("limit_done_no_err", {127'd0, err_timeout}, 128'd0);

    // Watchdog timeout.
    send(11'd64, 1'b0, 128'd128, 1'b0);
    repeat (201) @(negedge clk);
    check("err_before_limit", {127'd0, err_timeout}, 128'd0);
    check("busy_before_limit", {127'd0, blk_ready}, 128'd0);
    @(negedge clk);
    check("err_at_timeout", {127'd0, err_timeout}, 128'd1);
    check("ready_after_timeout", {127'd0, blk_ready}, 128'd1);
    check("t_acc_after_timeout", dut.t_acc_r, 128'd0);
    core_done = 1'b1;              // ignored in IDLE
    @(negedge clk);
    core_done = 1'b0;
    check("idle_done_ignored", {127'd0, blk_ready}, 128'd1);
    send(11'd8, 1'b0, 128'd8, 1'b1);
    done(0, 1'b0);
    check("err_sticky", {127'd0, err_timeout}, 128'd1);

    // Reset mid-WAIT, late core_done ignored.
    send(11'd32, 1'b1, 128'd40, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", {127'd0, blk_ready}, 128'd0);
    check("midrst_first", {127'd0, core_first}, 128'd1);
    check("midrst_core_t", core_t, 128'd0);
    check("midrst_err", {127'd0, err_timeout}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_release", {127'd0, blk_ready}, 128'd1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check("late_done_hash_valid", {127'd0, hash_valid}, 128'd0);
    check("late_done_ready", {127'd0, blk_ready}, 128'd1);
    check("late_done_t_acc", dut.t_acc_r, 128'd0);
    send(11'd1024, 1'b1, 128'd1024, 1'b1);
    done(0, 1'b1);
    handoff(0);

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
